// File: rtl/mips_cpu_hilo_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO register file.
// Iterative shift-add multiply (or single-cycle product when MUL_FAST) and restoring divide.
module mips_cpu_hilo_unit #(
    parameter int MUL_FAST = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        op_ready,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] operand;
    logic        is_div;
    logic        neg_p;
    logic        neg_r;

    logic        accept;
    logic        op_mul;
    logic        op_div;
    logic        op_signed;
    logic        b_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] fast_prod;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_sub;
    logic        div_ge;
    logic [63:0] acc_neg;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign op_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = op_valid & op_ready;
    assign op_mul    = (op[2:1] == 2'b00);
    assign op_div    = (op[2:1] == 2'b01);
    assign op_signed = (op_mul | op_div) & ~op[0];
    assign b_zero    = (b == '0);

    assign mag_a     = (op_signed && a[31]) ? (~a + 32'd1) : a;
    assign mag_b     = (op_signed && b[31]) ? (~b + 32'd1) : b;
    assign fast_prod = {32'd0, mag_a} * {32'd0, mag_b};

    // Multiply: acc holds {partial product, remaining multiplier bits}; operand is the multiplicand.
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);

    // Divide: acc holds {remainder, dividend/quotient}; operand is the divisor.
    assign div_shift = {acc[63:32], acc[31]};
    assign div_ge    = (div_shift >= {1'b0, operand});
    assign div_sub   = div_shift[31:0] - operand;

    assign acc_neg   = ~acc + 64'd1;
    assign q_fix     = neg_p ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign r_fix     = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_mul) begin
                        state_nxt = (MUL_FAST != 0) ? FIX : MUL;
                    end else if (op_div) begin
                        state_nxt = b_zero ? FIX : DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt == 5'd31) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_zero <= 1'b0;
                        cnt      <= '0;
                        is_div   <= op_div;
                        neg_p    <= op_signed & (a[31] ^ b[31]);
                        neg_r    <= op_signed & a[31];
                        if (op_mul) begin
                            operand <= mag_a;
                            acc     <= (MUL_FAST != 0) ? fast_prod : {32'd0, mag_b};
                        end else if (op_div) begin
                            operand  <= mag_b;
                            acc      <= {32'd0, mag_a};
                            div_zero <= b_zero;
                        end else if (op == 3'b100) begin
                            hi <= a;
                        end else if (op == 3'b101) begin
                            lo <= a;
                        end
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[31:1]};
                    cnt <= cnt + 5'd1;
                end
                DIV: begin
                    acc <= div_ge ? {div_sub, acc[30:0], 1'b1}
                                  : {div_shift[31:0], acc[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    // A divide-by-zero reaches FIX only to spend its one busy cycle.
                    if (!div_zero) begin
                        if (is_div) begin
                            lo <= q_fix;
                            hi <= r_fix;
                        end else begin
                            {hi, lo} <= neg_p ? acc_neg : acc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Scoreboard bench for mips_cpu_hilo_unit: driver pushes model results, monitor pops on completion.
module tb_mips_cpu_hilo_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, op_valid;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        op_ready, busy, div_zero;
    logic [31:0] hi, lo;

    logic        f_reset, f_valid;
    logic [2:0]  f_op;
    logic [31:0] f_a, f_b;
    logic        f_ready, f_busy, f_dz;
    logic [31:0] f_hi, f_lo;

    mips_cpu_hilo_unit #(.MUL_FAST(0)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .op_ready(op_ready), .busy(busy), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    mips_cpu_hilo_unit #(.MUL_FAST(1)) dut_f (
        .clk(clk), .reset(f_reset), .op_valid(f_valid), .op(f_op), .a(f_a), .b(f_b),
        .op_ready(f_ready), .busy(f_busy), .hi(f_hi), .lo(f_lo), .div_zero(f_dz)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp_v);
        end
    endtask

    // Reference results from plain 64-bit arithmetic; lat is the expected busy length.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        longint sx, sy, sr;
        longint unsigned ux, uy, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        e.hi = h; e.lo = l; e.dz = 1'b0; e.lat = 0;
        case (o)
            3'd0: begin sr = sx * sy; e.hi = sr[63:32]; e.lo = sr[31:0]; e.lat = 33; end
            3'd1: begin ur = ux * uy; e.hi = ur[63:32]; e.lo = ur[31:0]; e.lat = 33; end
            3'd2: begin
                if (y == 0) begin e.dz = 1'b1; e.lat = 1; end
                else begin
                    sr = sx / sy; e.lo = sr[31:0];
                    sr = sx % sy; e.hi = sr[31:0];
                    e.lat = 33;
                end
            end
            3'd3: begin
                if (y == 0) begin e.dz = 1'b1; e.lat = 1; end
                else begin
                    ur = ux / uy; e.lo = ur[31:0];
                    ur = ux % uy; e.hi = ur[31:0];
                    e.lat = 33;
                end
            end
            3'd4: e.hi = x;
            3'd5: e.lo = x;
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   n;
        e = model(o, x, y, model_hi, model_lo);
        @(negedge clk);
        op_valid = 1'b1; op = o; a = x; b = y;
        n = 0;
        while (!op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op_ready %b required 1", op_ready);
            op_valid = 1'b0;
            return;
        end
        model_hi = e.hi;
        model_lo = e.lo;
        sb.push_back(e);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic fast_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   n;
        e = model(o, x, y, f_hi, f_lo);
        @(negedge clk);
        f_valid = 1'b1; f_op = o; f_a = x; f_b = y;
        n = 0;
        while (!f_ready && n < 50) begin @(negedge clk); n++; end
        chk("fast_ready", f_ready, 1);
        @(posedge clk);
        #1 f_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (f_busy && n < 50) begin n++; @(negedge clk); end
        chk("fast_busy_cycles", n, 1);
        chk("fast_hi", f_hi, e.hi);
        chk("fast_lo", f_lo, e.lo);
    endtask

    // Monitor
    logic        started = 1'b0, accepted = 1'b0, rst_seen = 1'b0, counting = 1'b0, hold_ok = 1'b1;
    int          bcnt = 0;
    exp_t        cur;
    logic [31:0] mon_hi = '0, mon_lo = '0;
    logic        mon_dz = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            started  = 1'b1;
            rst_seen = 1'b1;
            accepted = 1'b0;
            sb.delete();
        end else if (op_valid && op_ready) begin
            accepted = 1'b1;
        end
    end

    task automatic complete_op();
        chk("hi", hi, cur.hi);
        chk("lo", lo, cur.lo);
        chk("div_zero", div_zero, cur.dz);
        mon_hi = cur.hi; mon_lo = cur.lo; mon_dz = cur.dz;
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (rst_seen) begin
                rst_seen = 1'b0; counting = 1'b0;
                mon_hi = '0; mon_lo = '0; mon_dz = 1'b0;
                chk("reset_hi", hi, 0);
                chk("reset_lo", lo, 0);
                chk("reset_div_zero", div_zero, 0);
                chk("reset_op_ready", op_ready, 1);
                chk("reset_busy", busy, 0);
            end else begin
                if (accepted) begin
                    accepted = 1'b0;
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_accept: queue size 0 required >0");
                    end else begin
                        cur = sb.pop_front();
                        if (cur.lat == 0) complete_op();
                        else begin counting = 1'b1; bcnt = 0; hold_ok = 1'b1; end
                    end
                end
                if (counting) begin
                    if (busy) begin
                        bcnt++;
                        if (hi !== mon_hi || lo !== mon_lo || op_ready !== 1'b0) hold_ok = 1'b0;
                        if (bcnt > 100) begin
                            counting = 1'b0;
                            checks++; errors++;
                            $display("FAIL busy_timeout: busy %0d cycles required %0d", bcnt, cur.lat);
                        end
                    end else begin
                        counting = 1'b0;
                        chk("hold_while_busy", hold_ok, 1);
                        chk("busy_cycles", bcnt, cur.lat);
                        complete_op();
                    end
                end else begin
                    chk("idle_busy", busy, 0);
                    chk("idle_op_ready", op_ready, 1);
                    chk("idle_hi", hi, mon_hi);
                    chk("idle_lo", lo, mon_lo);
                    chk("idle_div_zero", div_zero, mon_dz);
                end
            end
        end
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        int          n;
        reset = 1'b1; op_valid = 1'b0; op = '0; a = '0; b = '0;
        f_reset = 1'b1; f_valid = 1'b0; f_op = '0; f_a = '0; f_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0; f_reset = 1'b0;

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(3'd0, 32'hFFFFFFFD, 32'd5);
        issue(3'd0, 32'h80000000, 32'h80000000);
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        issue(3'd3, 32'd100, 32'd7);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        issue(3'd4, 32'h1234, 32'd0);
        issue(3'd5, 32'h5678, 32'd0);
        issue(3'd3, 32'd7, 32'd0);
        issue(3'd6, 32'd1, 32'd1);
        issue(3'd3, 32'd1000, 32'd3);
        issue(3'd5, 32'hAAAA, 32'd0);

        issue(3'd4, 32'hBEEF, 32'd0);
        issue(3'd0, 32'd7, 32'd9);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ry = '0;
                1: ry = 32'($urandom_range(1, 16));
                2: rx = 32'h80000000;
                3: ry = 32'hFFFFFFFF;
                default: ;
            endcase
            issue(ro, rx, ry);
        end

        n = 0;
        while ((sb.size() != 0 || counting || accepted) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);

        fast_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        fast_op(3'd0, 32'hFFFFFFFD, 32'd5);
        fast_op(3'd0, 32'h80000000, 32'h80000000);
        for (int i = 0; i < 6; i++) begin
            fast_op(3'($urandom_range(0, 1)), $urandom, $urandom);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_hilo_unit.md
# mips_cpu_hilo_unit

Multi-cycle multiply/divide sequencer and HI/LO register file for the MIPS core. It sits beside the single-cycle ALU and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply uses an iterative shift-add datapath and divide uses an iterative restoring datapath, so no wide combinational multiplier or divider is left in the execute stage. The execute stage issues operations through a valid/ready handshake. It must stall MFHI/MFLO while `busy` is high.

## Interface
Parameters:
- `MUL_FAST`, default 0. 0: multiply is iterative (32 steps). 1: multiply uses one combinational 32x32 product and completes in 1 cycle.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  operation request.
- `op`  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 11x are treated as a no-op and are accepted.
- `a`  in  32  rs operand: multiplicand or dividend; source for MTHI/MTLO.
- `b`  in  32  rt operand: multiplier or divisor.
- `op_ready`  out  1  high only in IDLE. An operation is accepted on an edge where `op_valid & op_ready`.
- `busy`  out  1  high in any state other than IDLE. While high, HI/LO are stale.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `div_zero`  out  1  set by a DIV/DIVU with `b==0`. Cleared by the next accepted op.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, on accept, registers `a`, `b` and `op`, and clears `div_zero`. Then:
  - MTHI: `hi<=a`, stay in IDLE.
  - MTLO: `lo<=a`, stay in IDLE.
  - MULT/MULTU: go to MUL. If `MUL_FAST=1`, go directly to FIX with the product latched.
  - DIV/DIVU with `b!=0`: go to DIV.
  - DIV/DIVU with `b==0`: set `div_zero`, go to FIX with no write pending.
- Signed ops (MULT, DIV): operate on magnitudes (`~x+1` when the sign bit is set) and record `neg_p = a[31]^b[31]` and `neg_r = a[31]`.
- MUL: a 5-bit step counter runs 0..31. Each step: if the multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit accumulator; then shift the accumulator right by 1. After step 31, go to FIX.
- DIV: a 5-bit step counter runs 0..31. Each step: shift the remainder:quotient pair left, trial-subtract the divisor, and keep the result and set the quotient bit if it is non-negative. After step 31, go to FIX.
- FIX: applies sign correction, then writes:
  - MULT: `{hi,lo} <= neg_p ? -prod : prod`, 64-bit.
  - DIV: `lo <= neg_p ? -q : q`, `hi <= neg_r ? -r : r`.
  - Unsigned ops write results unchanged.
  - If `div_zero`, HI/LO are not written.
  - Always return to IDLE.
- Boundaries:
  - `0x80000000/0xFFFFFFFF` (DIV): `lo=0x80000000`, `hi=0`.
  - MULT `0x80000000*0x80000000`: `hi=0x40000000`, `lo=0`.
  - `op_valid` while busy: ignored, not queued. The requester must hold it until `op_ready`.
- Reset, including mid-operation: state IDLE, `hi=lo=0`, `div_zero=0`, counters 0. The in-flight operation is discarded.

## Timing
- Reset values: `op_ready=1`, `busy=0`, `hi=0`, `lo=0`, `div_zero=0`.
- Let E0 be the accept edge.
- MTHI/MTLO: new value is visible after E0. `busy` stays 0.
- Iterative MUL or DIV: steps occur on E1..E32, FIX on E33.
  - `busy=1` from after E0 until E33.
  - HI/LO update at E33.
  - `op_ready=1` after E33, so the next accept is at E34 at the earliest.
- `MUL_FAST=1` multiply, and divide-by-zero: FIX on E1. `busy` is high for exactly 1 cycle.
- HI/LO hold their value throughout an operation and change only at FIX. Intermediate values are never visible.
- `op_ready` and `busy` are registered state decodes and are always complements of each other.

## Test plan
- MULTU `a=0xFFFFFFFF`, `b=0xFFFFFFFF` -> `busy` is high for 33 cycles, then `hi=0xFFFFFFFE`, `lo=0x00000001`. With `MUL_FAST=1`, the same result appears after 1 busy cycle.
- MULT `a=0xFFFFFFFD` (-3), `b=5` -> `hi=0xFFFFFFFF`, `lo=0xFFFFFFF1`. Then MULT `0x80000000*0x80000000` -> `hi=0x40000000`, `lo=0`.
- DIV `a=0xFFFFFFF9` (-7), `b=2` -> `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. DIVU `a=100`, `b=7` -> `lo=14`, `hi=2`. DIV `0x80000000/0xFFFFFFFF` -> `lo=0x80000000`, `hi=0`.
- MTHI `0x1234`, MTLO `0x5678`, then DIVU `a=7`, `b=0` -> `div_zero=1`, `busy` high 1 cycle, `hi=0x1234`, `lo=0x5678` unchanged. The next accepted op clears `div_zero`.
- Start DIVU, hold `op_valid` with MTLO `0xAAAA` while busy -> MTLO is ignored until `op_ready`, then accepted the cycle after FIX. The final `lo` is `0xAAAA`, not the quotient.
- Start MULT, assert `reset` on step 10 -> after the edge: IDLE, `op_ready=1`, `hi=lo=0`, no later write occurs.
